mpmc10_resp_fifo256: RTL

Return-path buffer for the mpmc10 memory controller. It accepts 256-bit read responses from the controller core and holds them in a small FIFO. It then presents them to a port's consumer through a valid/ready handshake. It sits between the controller's response output and each port's clock-synchronous consumer. It is the counterpart of the request-side register stage: requests flow toward memory, responses flow back through this block.

---
 rtl/mpmc10_pkg.sv | 29 ++
 rtl/mpmc10_resp_ram.sv | 40 ++++
 rtl/mpmc10_resp_fifo256.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mpmc10_pkg.sv
// -----------------------------------------------------------------------------
// mpmc10_pkg
//
// Shared types and defaults for the mpmc10 memory controller return path.
//
// Contents:
//   faxi_read_response256_t  - one read response beat: tag, 256-bit data,
//                              response code and last-beat marker.
//   MPMC10_RESP_FIFO_DEPTH   - default entry count of the response FIFO.
//   mpmc10_is_pow2()         - helper used to sanity-check depth parameters.
// -----------------------------------------------------------------------------
package mpmc10_pkg;

    typedef struct packed {
        logic [7:0]   tag;
        logic [255:0] data;
        logic [1:0]   resp;
        logic         last;
    } faxi_read_response256_t;

    localparam int MPMC10_RESP_FIFO_DEPTH = 4;

    // True when n is a power of two and at least 2; the FIFO pointers rely on
    // natural binary wrap, which only works for such depths.
    function automatic bit mpmc10_is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/mpmc10_resp_ram.sv
// -----------------------------------------------------------------------------
// mpmc10_resp_ram
//
// Storage array for the response FIFO: DEPTH entries of one read response
// each, one synchronous write port and one asynchronous read port. The array
// carries data only, so it has no reset; the owning FIFO tracks validity.
//
// Ports:
//   clk    in   write clock (rising edge)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   response word to store
//   raddr  in   read address
//   rdata  out  response word at raddr (combinational)
// -----------------------------------------------------------------------------
module mpmc10_resp_ram
    import mpmc10_pkg::*;
#(
    parameter int DEPTH = MPMC10_RESP_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  faxi_read_response256_t wdata,
    input  logic [AW-1:0]          raddr,
    output faxi_read_response256_t rdata
);

    faxi_read_response256_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mpmc10_resp_fifo256.sv
// -----------------------------------------------------------------------------
// mpmc10_resp_fifo256
//
// Return-path buffer between the mpmc10 controller core and a port consumer.
// Read responses are queued in a small circular buffer and handed out through
// a valid/ready handshake with a registered head word.
//
// Ports:
//   clk      in   controller clock, all state changes on the rising edge
//   rst      in   synchronous active-high reset
//   i        in   response word from the controller core
//   i_valid  in   i holds a response this cycle
//   i_ready  out  registered; an entry is free
//   o        out  registered head-of-FIFO response
//   o_valid  out  o holds a valid response
//   o_ready  in   consumer takes o this cycle
//   count    out  registered occupancy
//   afull    out  registered; count >= AFULL_LEVEL
//   ovf      out  sticky: a word arrived while i_ready was low
//
// The core cannot stall DRAM read data, so i_ready is only advisory. A word
// offered while i_ready is low is dropped and ovf latches until reset.
// -----------------------------------------------------------------------------
module mpmc10_resp_fifo256
    import mpmc10_pkg::*;
#(
    parameter int DEPTH       = MPMC10_RESP_FIFO_DEPTH,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  faxi_read_response256_t i,
    input  logic                   i_valid,
    output logic                   i_ready,
    output faxi_read_response256_t o,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   afull,
    output logic                   ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] ONE_CNT   = CW'(1);

    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          next_head_addr;
    logic                   push;
    logic                   pop;
    logic [CW-1:0]          count_next;
    faxi_read_response256_t ram_rdata;
    faxi_read_response256_t o_next;

    assign push = i_valid & i_ready;
    assign pop  = o_valid & o_ready;

    // The entry behind the current head; it becomes the new head on a pop
    // whenever at least two words are stored.
    assign next_head_addr = rd_ptr + PW'(1);

    mpmc10_resp_ram #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (i),
        .raddr (next_head_addr),
        .rdata (ram_rdata)
    );

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + ONE_CNT;
            2'b01:   count_next = count - ONE_CNT;
            default: count_next = count;
        endcase
    end

    // Head register update. Every push is also written to the array, so the
    // head is duplicated there; the array copy is simply never read back.
    // When the FIFO is about to hold exactly the incoming word (push into an
    // empty FIFO, or push+pop with one entry) the head loads straight from i,
    // because that word is not yet in the array this cycle.
    always_comb begin
        o_next = o;
        if (count_next == '0) begin
            o_next = '0;
        end else if ((count == '0) || (pop && (count == ONE_CNT))) begin
            o_next = i;
        end else if (pop) begin
            o_next = ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            o_valid <= 1'b0;
            o       <= '0;
            i_ready <= 1'b0;
            afull   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count   <= count_next;
            o_valid <= (count_next != '0);
            o       <= o_next;
            i_ready <= (count_next != FULL_CNT);
            afull   <= (count_next >= AFULL_CNT);
            if (i_valid && !i_ready) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule
